// File: rtl/ceespu_fetch_pkg.sv
// Shared definitions for the ceespu instruction-fetch stage: state encodings,
// default addresses/bubble word and the wrapping PC increment.
package ceespu_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_BOOT     = 2'd0,
        FETCH_RUN      = 2'd1,
        FETCH_REDIRECT = 2'd2
    } fetch_state_t;

    localparam logic [13:0] DEF_RESET_PC   = 14'h0000;
    localparam logic [13:0] DEF_INT_VECTOR = 14'h0004;
    // ADD r0,r0,r0: regd=0 so decode never writes the register file
    localparam logic [31:0] DEF_NOP_INSTR  = 32'h0000_0000;

    function automatic logic [13:0] pc_inc(input logic [13:0] pc);
        return pc + 14'd1;
    endfunction

endpackage

// File: rtl/ceespu_fetch.sv
// Instruction fetch: owns the word PC, drives the 1-cycle-latency instruction
// memory, inserts bubbles after boot/branch/interrupt and holds the return PC.
module ceespu_fetch
    import ceespu_fetch_pkg::*;
#(
    parameter logic [13:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [13:0] INT_VECTOR = DEF_INT_VECTOR,
    parameter logic [31:0] NOP_INSTR  = DEF_NOP_INSTR
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_stall,
    input  logic        I_branch,
    input  logic [13:0] I_branch_target,
    input  logic        I_int_req,
    input  logic        I_interrupts_enabled,
    input  logic [31:0] I_imem_data,
    output logic [13:0] O_imem_addr,
    output logic [31:0] O_instruction,
    output logic [13:0] O_PC,
    output logic        O_valid,
    output logic        O_did_interrupt,
    output logic [13:0] O_epc
);

    fetch_state_t state, state_next;
    logic [13:0]  pc, pc_next;
    logic         valid, valid_next;
    logic [13:0]  epc_next;
    logic         did_int_next;
    logic         take_int;

    // Next-address mux; pc always holds the address issued in the previous cycle
    always_comb begin
        take_int     = (state == FETCH_RUN) && valid && I_int_req &&
                       I_interrupts_enabled && !I_stall;
        O_imem_addr  = pc_inc(pc);
        pc_next      = pc_inc(pc);
        valid_next   = valid;
        state_next   = state;
        epc_next     = O_epc;
        did_int_next = 1'b0;

        if (I_branch) begin
            // The stall belongs to the decode slot being squashed, so it is ignored
            O_imem_addr = I_branch_target;
            pc_next     = I_branch_target;
            valid_next  = 1'b0;
            state_next  = FETCH_REDIRECT;
        end else if (take_int) begin
            // Squashed instruction at pc re-executes on return
            O_imem_addr  = INT_VECTOR;
            pc_next      = INT_VECTOR;
            epc_next     = pc;
            valid_next   = 1'b0;
            state_next   = FETCH_REDIRECT;
            did_int_next = 1'b1;
        end else if (state != FETCH_RUN) begin
            O_imem_addr = pc;
            pc_next     = pc;
            valid_next  = 1'b1;
            state_next  = FETCH_RUN;
        end else if (I_stall) begin
            O_imem_addr = pc;
            pc_next     = pc;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state           <= FETCH_BOOT;
            pc              <= RESET_PC;
            valid           <= 1'b0;
            O_epc           <= 14'd0;
            O_did_interrupt <= 1'b0;
        end else begin
            state           <= state_next;
            pc              <= pc_next;
            valid           <= valid_next;
            O_epc           <= epc_next;
            O_did_interrupt <= did_int_next;
        end
    end

    assign O_PC          = pc;
    assign O_valid       = valid;
    assign O_instruction = valid ? I_imem_data : NOP_INSTR;

endmodule

// File: tb/tb_ceespu_fetch.sv
// Directed bench for ceespu_fetch: memory word n holds value n, so every
// delivered instruction must equal its own PC.
module tb_ceespu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [13:0] branch_target;
    logic        int_req;
    logic        int_en;
    logic [31:0] imem_data = 32'd0;
    logic [13:0] imem_addr;
    logic [31:0] instruction;
    logic [13:0] pc;
    logic        valid;
    logic        did_int;
    logic [13:0] epc;

    int total = 0;
    int bad   = 0;

    ceespu_fetch dut (
        .I_clk               (clk),
        .I_rst               (rst),
        .I_stall             (stall),
        .I_branch            (branch),
        .I_branch_target     (branch_target),
        .I_int_req           (int_req),
        .I_interrupts_enabled(int_en),
        .I_imem_data         (imem_data),
        .O_imem_addr         (imem_addr),
        .O_instruction       (instruction),
        .O_PC                (pc),
        .O_valid             (valid),
        .O_did_interrupt     (did_int),
        .O_epc               (epc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= {18'd0, imem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Delivered slot: PC, valid flag, instruction word
    task automatic chk_slot(input string tag, input logic [13:0] exp_pc,
                            input logic exp_valid, input logic [31:0] exp_instr);
        chk({tag, "_pc"},    {18'd0, pc},    {18'd0, exp_pc});
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_valid});
        chk({tag, "_instr"}, instruction,    exp_instr);
    endtask

    task automatic chk_addr(input string tag, input logic [13:0] exp);
        #1;
        chk(tag, {18'd0, imem_addr}, {18'd0, exp});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; branch_target = 14'd0;
        int_req = 1'b0; int_en = 1'b0;
        tick();
        tick();
        chk_slot("reset", 14'h0000, 1'b0, 32'h0);
        chk("reset_epc", {18'd0, epc}, 32'h0);
        chk("reset_didint", {31'd0, did_int}, 32'h0);
        rst = 1'b0;
        chk_addr("boot_addr", 14'h0000);

        // Sequential fetch: address leads delivered PC by one
        for (int n = 0; n < 6; n++) begin
            tick();
            chk_slot("seq", 14'(n), 1'b1, 32'(n));
            if (n < 5) chk_addr("seq_addr", 14'(n + 1));
        end

        // Stall three cycles at PC 5
        stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            chk_addr("stall_addr", 14'h0005);
            tick();
            chk_slot("stall", 14'h0005, 1'b1, 32'h5);
        end
        stall = 1'b0;
        chk_addr("unstall_addr", 14'h0006);
        tick();
        chk_slot("resume6", 14'h0006, 1'b1, 32'h6);
        tick();
        chk_slot("resume7", 14'h0007, 1'b1, 32'h7);

        // Branch with simultaneous stall
        branch = 1'b1; branch_target = 14'h0100; stall = 1'b1;
        chk_addr("br_addr", 14'h0100);
        tick();
        branch = 1'b0; stall = 1'b0;
        chk_slot("br_bubble", 14'h0100, 1'b0, 32'h0);
        chk_addr("br_redir_addr", 14'h0100);
        tick();
        chk_slot("br_target", 14'h0100, 1'b1, 32'h100);

        // Request with interrupts disabled is ignored
        int_req = 1'b1; int_en = 1'b0;
        chk_addr("intdis_addr", 14'h0101);
        tick();
        chk_slot("intdis", 14'h0101, 1'b1, 32'h101);
        chk("intdis_didint", {31'd0, did_int}, 32'h0);

        // Branch and interrupt together: branch wins
        int_en = 1'b1; branch = 1'b1; branch_target = 14'h0009;
        chk_addr("brint_addr", 14'h0009);
        tick();
        branch = 1'b0;
        chk_slot("brint_bubble", 14'h0009, 1'b0, 32'h0);
        chk("brint_didint", {31'd0, did_int}, 32'h0);
        chk_addr("brint_redir_addr", 14'h0009);
        tick();
        chk_slot("brint_target", 14'h0009, 1'b1, 32'h9);
        // First eligible RUN cycle takes the pending request
        chk_addr("int_addr", 14'h0004);
        tick();
        int_req = 1'b0;
        chk_slot("int_bubble", 14'h0004, 1'b0, 32'h0);
        chk("int_didint", {31'd0, did_int}, 32'h1);
        chk("int_epc", {18'd0, epc}, 32'h9);
        tick();
        chk_slot("int_vector", 14'h0004, 1'b1, 32'h4);
        chk("int_didint_off", {31'd0, did_int}, 32'h0);
        chk("int_epc_hold", {18'd0, epc}, 32'h9);

        // PC wrap at top of address space
        branch = 1'b1; branch_target = 14'h3FFE;
        tick();
        branch = 1'b0;
        tick();
        chk_slot("wrap_3ffe", 14'h3FFE, 1'b1, 32'h3FFE);
        tick();
        chk_slot("wrap_3fff", 14'h3FFF, 1'b1, 32'h3FFF);
        chk_addr("wrap_addr", 14'h0000);
        tick();
        chk_slot("wrap_0", 14'h0000, 1'b1, 32'h0);

        // Reset mid-REDIRECT with a simultaneous branch
        branch = 1'b1; branch_target = 14'h0020;
        tick();
        chk_slot("pre_rst_bubble", 14'h0020, 1'b0, 32'h0);
        chk("pre_rst_epc", {18'd0, epc}, 32'h9);
        rst = 1'b1; branch_target = 14'h0030;
        tick();
        rst = 1'b0; branch = 1'b0;
        chk_slot("rst_redir", 14'h0000, 1'b0, 32'h0);
        chk("rst_redir_epc", {18'd0, epc}, 32'h0);
        chk("rst_redir_didint", {31'd0, did_int}, 32'h0);
        chk_addr("rst_redir_addr", 14'h0000);
        tick();
        chk_slot("rst_first", 14'h0000, 1'b1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ceespu_fetch.md
Name: ceespu_fetch

Overview:
Instruction-fetch stage of the ceespu pipeline, directly upstream of the decoder.
- Owns the 14-bit word PC and drives the synchronous instruction memory (1-cycle read latency).
- Presents instruction/PC pairs to decode, and inserts NOP bubbles after reset, taken branches and interrupt entry.
- Tracks interrupt entry and holds the exception return PC.

Parameters:
RESET_PC, 14'h0000, word address fetched first after reset
INT_VECTOR, 14'h0004, word address of interrupt handler
NOP_INSTR, 32'h0000_0000, instruction word emitted as bubble (ADD r0 form, we=0 because regd=0)

Ports:
I_clk  in  1  clock, all state on rising edge
I_rst  in  1  synchronous active-high reset
I_stall  in  1  decode hazard stall; hold delivered instruction/PC
I_branch  in  1  taken branch/jump resolved in execute
I_branch_target  in  14  word address of branch destination
I_int_req  in  1  level interrupt request
I_interrupts_enabled  in  1  interrupt enable flag from decode
I_imem_data  in  32  instruction memory read data (addr of previous cycle)
O_imem_addr  out  14  instruction memory read address (combinational)
O_instruction  out  32  instruction to decode
O_PC  out  14  word address of O_instruction
O_valid  out  1  O_instruction is a real fetched instruction (0 = bubble)
O_did_interrupt  out  1  one-cycle pulse on interrupt entry
O_epc  out  14  return PC latched at interrupt entry

Behaviour:
- Registers: pc (address issued last cycle), valid, state, epc, int pulse.
- Reset (I_rst=1 at edge): pc<=RESET_PC, state<=BOOT, valid<=0, O_epc<=0, O_did_interrupt<=0. O_instruction=NOP_INSTR, O_PC=RESET_PC while valid=0.
- O_instruction = valid ? I_imem_data : NOP_INSTR. O_PC = pc. Both combinational from registers and memory data.
- States:
  - BOOT: one cycle; O_imem_addr=pc. Next cycle: RUN, valid<=1.
  - RUN: normal sequential fetch.
  - REDIRECT: one bubble cycle after branch or interrupt; O_imem_addr=pc (new target). Next cycle: RUN, valid<=1.
- Next-address priority, evaluated in every state:
  1. I_branch: O_imem_addr=I_branch_target; pc<=target; valid<=0; state<=REDIRECT. Branch overrides I_stall, which comes from the squashed decode slot. Branch during REDIRECT restarts REDIRECT.
  2. Interrupt, taken when state=RUN, valid=1, I_int_req=1, I_interrupts_enabled=1, I_stall=0:
     - O_imem_addr=INT_VECTOR; epc<=pc (the squashed instruction re-executes on return); pc<=INT_VECTOR; valid<=0; state<=REDIRECT.
     - O_did_interrupt<=1 for exactly one cycle, aligned with the first bubble.
  3. I_stall: O_imem_addr=pc; pc, valid and state unchanged. Memory re-reads the same word, so O_instruction stays stable.
  4. Otherwise: O_imem_addr=pc+1 (14-bit wrap 14'h3FFF->14'h0000); pc<=pc+1.
- Latency: a branch asserted in cycle t gives a NOP in t+1 and the target instruction (O_valid=1) in t+2.
- No interrupt is taken in BOOT, in REDIRECT, or while O_valid=0. A request held through these is taken at the first eligible RUN cycle.
- O_did_interrupt deasserts the next cycle regardless of I_int_req.
- Reset has priority over everything, including mid-REDIRECT and a simultaneous I_branch.

Decomposition:
- Add FETCH_BOOT/FETCH_RUN/FETCH_REDIRECT state encodings (2-bit) and the default NOP encoding to ceespu_constants.vh.
- Single module; no sub-module warranted. The next-PC mux stays inline as one always @* block.

Test Plan:
- Reset then 5 free cycles, imem word n = n: O_valid 0 at cycle 1, then O_PC 0,1,2,3 with O_instruction 0,1,2,3; O_imem_addr leads O_PC by 1.
- I_stall high 3 cycles at O_PC=5: O_PC=5, O_instruction unchanged, O_imem_addr=5 throughout; resumes with 6.
- I_branch=1, target 14'h0100 at O_PC=7 with I_stall=1 simultaneously: next cycle NOP_INSTR/O_valid=0, following cycle O_PC=0x100, O_valid=1.
- I_int_req=1, I_interrupts_enabled=1 at O_PC=9: O_epc=9, one-cycle O_did_interrupt with NOP, then O_PC=INT_VECTOR; with enable=0 the request is ignored.
- Interrupt and branch in the same cycle: branch wins, no O_did_interrupt; interrupt is taken the first RUN cycle after the target arrives.
- pc=14'h3FFF sequential: next O_PC=14'h0000. I_rst asserted in REDIRECT: O_PC=RESET_PC, bubble, O_epc=0.
